hera_trace_tx: RTL and testbench

Retirement-trace transmitter for the HERA core. It captures one record per retired instruction: PC, instruction word, register write-back, and the S/Z/V/C/CB flags. Records are buffered in a small FIFO and sent as a framed byte stream over a valid/ready interface. The block sits beside the register file and ALU and gives an external monitor a cycle-independent view of architectural state, without hierarchical peeking.

---
 rtl/hera_trace_tx.sv | 139 +++++++++++++
 tb/tb_hera_trace_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hera_trace_tx.sv
// Retirement-trace transmitter: queues one record per retired instruction and
// streams each one as a 9-byte frame over a valid/ready byte interface.
module hera_trace_tx #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       trace_en,
   input  logic                       retire_valid,
   input  logic [15:0]                retire_pc,
   input  logic [15:0]                retire_instr,
   input  logic                       retire_wr_en,
   input  logic [3:0]                 retire_wr_reg,
   input  logic [15:0]                retire_wr_data,
   input  logic [4:0]                 retire_flags,
   output logic                       tx_valid,
   output logic [7:0]                 tx_data,
   output logic                       tx_last,
   input  logic                       tx_ready,
   output logic [7:0]                 drop_cnt,
   output logic [$clog2(DEPTH):0]     fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      logic        wr_en;
      logic [2:0]  seq;
      logic [3:0]  wr_reg;
      logic [15:0] pc;
      logic [15:0] instr;
      logic [15:0] wr_data;
      logic        lost;
      logic [4:0]  flags;
   } rec_t;

   typedef enum logic {IDLE, SEND} state_t;

   // Handshake: a byte moves on a rising edge where tx_valid && tx_ready.
   // tx_valid/tx_data/tx_last depend only on registered state, never on tx_ready.
   rec_t            mem [DEPTH];
   rec_t            head;
   rec_t            new_rec;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [LW-1:0]   count, count_d;
   logic [3:0]      b;
   logic [2:0]      seq;
   logic            lost;
   state_t          state_q, state_d;
   logic            want, hs, pop, push, drop;

   assign want = trace_en && retire_valid;
   assign hs   = tx_valid && tx_ready;
   assign pop  = hs && (b == 4'd8);
   // A full queue still accepts a record on the edge that pops the head.
   assign push = want && ((count < LW'(DEPTH)) || pop);
   assign drop = want && !push;

   always_comb begin
      new_rec         = '0;
      new_rec.wr_en   = retire_wr_en;
      new_rec.seq     = seq;
      new_rec.wr_reg  = retire_wr_reg;
      new_rec.pc      = retire_pc;
      new_rec.instr   = retire_instr;
      new_rec.wr_data = retire_wr_en ? retire_wr_data : 16'h0000;
      new_rec.lost    = lost;
      new_rec.flags   = retire_flags;
   end

   always_comb begin
      count_d = count;
      if (push && !pop)
         count_d = count + LW'(1);
      else if (pop && !push)
         count_d = count - LW'(1);
      state_d = (count_d != '0) ? SEND : IDLE;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= new_rec;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         b        <= 4'd0;
         seq      <= 3'd0;
         lost     <= 1'b0;
         drop_cnt <= 8'd0;
      end else begin
         state_q <= state_d;
         count   <= count_d;
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            seq    <= seq + 3'd1;
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (hs)
            b <= (b == 4'd8) ? 4'd0 : b + 4'd1;
         if (drop)
            lost <= 1'b1;
         else if (push)
            lost <= 1'b0;
         if (drop && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

   assign head       = mem[rd_ptr];
   assign tx_valid   = (state_q == SEND);
   assign tx_last    = tx_valid && (b == 4'd8);
   assign fifo_level = count;

   always_comb begin
      tx_data = 8'h00;
      if (tx_valid) begin
         case (b)
            4'd0:    tx_data = 8'hA5;
            4'd1:    tx_data = {head.wr_en, head.seq, head.wr_reg};
            4'd2:    tx_data = head.pc[15:8];
            4'd3:    tx_data = head.pc[7:0];
            4'd4:    tx_data = head.instr[15:8];
            4'd5:    tx_data = head.instr[7:0];
            4'd6:    tx_data = head.wr_data[15:8];
            4'd7:    tx_data = head.wr_data[7:0];
            4'd8:    tx_data = {head.lost, 2'b00, head.flags};
            default: tx_data = 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_hera_trace_tx.sv
// Directed bench for hera_trace_tx: framing, backpressure, overflow, reset.
module tb_hera_trace_tx;

   logic        clk;
   logic        rst;
   logic        trace_en;
   logic        retire_valid;
   logic [15:0] retire_pc;
   logic [15:0] retire_instr;
   logic        retire_wr_en;
   logic [3:0]  retire_wr_reg;
   logic [15:0] retire_wr_data;
   logic [4:0]  retire_flags;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_last;
   logic        tx_ready;
   logic [7:0]  drop_cnt;
   logic [2:0]  fifo_level;

   int checks = 0;
   int errors = 0;

   hera_trace_tx #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst), .trace_en(trace_en), .retire_valid(retire_valid),
      .retire_pc(retire_pc), .retire_instr(retire_instr), .retire_wr_en(retire_wr_en),
      .retire_wr_reg(retire_wr_reg), .retire_wr_data(retire_wr_data),
      .retire_flags(retire_flags), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_last(tx_last), .tx_ready(tx_ready), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [71:0] mk(input logic we, input logic [2:0] sq, input logic [3:0] rg,
                                      input logic [15:0] pc, input logic [15:0] ins,
                                      input logic [15:0] dat, input logic lst, input logic [4:0] fl);
      logic [15:0] d;
      d = we ? dat : 16'h0000;
      return {8'hA5, we, sq, rg, pc, ins, d, lst, 2'b00, fl};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      retire_valid = 1'b0;
      tx_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic retire(input logic [15:0] pc, input logic [15:0] ins, input logic we,
                         input logic [3:0] rg, input logic [15:0] dat, input logic [4:0] fl);
      retire_valid   = 1'b1;
      retire_pc      = pc;
      retire_instr   = ins;
      retire_wr_en   = we;
      retire_wr_reg  = rg;
      retire_wr_data = dat;
      retire_flags   = fl;
      step();
      retire_valid = 1'b0;
   endtask

   task automatic check_val(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic recv_frame(input logic [71:0] e, input bit toggle, input bit b2b, input string nm);
      int i;
      int cyc;
      bit ph;
      logic [7:0] eb;
      i = 0;
      cyc = 0;
      ph = 1'b0;
      if (b2b) begin
         checks++;
         if (tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s start: tx_valid=%b expected 1", nm, tx_valid);
         end
      end
      while (i < 9 && cyc < 100) begin
         tx_ready = toggle ? ph : 1'b1;
         eb = e[71 - 8*i -: 8];
         if (tx_valid) begin
            checks++;
            if (tx_data !== eb || tx_last !== (i == 8)) begin
               errors++;
               $display("FAIL %s byte %0d (ready=%b): data=%h last=%b expected data=%h last=%b",
                        nm, i, tx_ready, tx_data, tx_last, eb, (i == 8));
            end
            if (tx_ready) i++;
         end
         ph = ~ph;
         step();
         cyc++;
      end
      tx_ready = 1'b1;
      if (i < 9) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: got %0d bytes expected 9", nm, i);
      end
   endtask

   task automatic test_reset();
      do_reset();
      check_val("reset tx_valid", {7'b0, tx_valid}, 8'h00);
      check_val("reset tx_data", tx_data, 8'h00);
      check_val("reset tx_last", {7'b0, tx_last}, 8'h00);
      check_val("reset drop_cnt", drop_cnt, 8'h00);
      check_val("reset fifo_level", {5'b0, fifo_level}, 8'h00);
   endtask

   task automatic test_trace_en();
      do_reset();
      trace_en = 1'b0;
      retire(16'h0040, 16'h1111, 1'b1, 4'd1, 16'h2222, 5'b00001);
      check_val("trace_en off level", {5'b0, fifo_level}, 8'h00);
      check_val("trace_en off valid", {7'b0, tx_valid}, 8'h00);
      trace_en = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      retire(16'h0010, 16'hE123, 1'b1, 4'd3, 16'h00FF, 5'b01001);
      recv_frame(72'hA5_83_00_10_E1_23_00_FF_09, 1'b0, 1'b1, "single");
      check_val("single idle after", {7'b0, tx_valid}, 8'h00);
      check_val("single level after", {5'b0, fifo_level}, 8'h00);
   endtask

   task automatic test_backpressure();
      do_reset();
      retire(16'h0010, 16'hE123, 1'b1, 4'd3, 16'h00FF, 5'b01001);
      recv_frame(72'hA5_83_00_10_E1_23_00_FF_09, 1'b1, 1'b1, "backpressure");
   endtask

   task automatic test_overflow();
      do_reset();
      tx_ready = 1'b0;
      for (int i = 0; i < 6; i++)
         retire(16'h0100 + 16'(i), 16'h1000 + 16'(i), 1'b1, 4'(i), 16'h0A00 + 16'(i), 5'(i + 1));
      check_val("overflow level", {5'b0, fifo_level}, 8'h04);
      check_val("overflow drop_cnt", drop_cnt, 8'h02);
      for (int i = 0; i < 4; i++)
         recv_frame(mk(1'b1, 3'(i), 4'(i), 16'h0100 + 16'(i), 16'h1000 + 16'(i),
                       16'h0A00 + 16'(i), 1'b0, 5'(i + 1)), 1'b0, 1'b1, "overflow drain");
      check_val("overflow empty", {5'b0, fifo_level}, 8'h00);
      retire(16'h0200, 16'h2000, 1'b1, 4'd9, 16'h1234, 5'b10000);
      recv_frame(72'hC9_02_00_20_00_12_34_90 | 72'hA5_00_00_00_00_00_00_00_00,
                 1'b0, 1'b1, "overflow lost");
   endtask

   task automatic test_full_push_on_pop();
      int cyc;
      do_reset();
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         retire(16'h0300 + 16'(i), 16'h3000 + 16'(i), 1'b1, 4'(i), 16'h0B00 + 16'(i), 5'b00010);
      tx_ready = 1'b1;
      cyc = 0;
      while (tx_last !== 1'b1 && cyc < 50) begin
         step();
         cyc++;
      end
      check_val("pushpop reached last", {7'b0, tx_last}, 8'h01);
      retire(16'h0400, 16'h4000, 1'b1, 4'd5, 16'hCAFE, 5'b00100);
      check_val("pushpop level", {5'b0, fifo_level}, 8'h04);
      check_val("pushpop drop_cnt", drop_cnt, 8'h00);
      for (int i = 1; i < 4; i++)
         recv_frame(mk(1'b1, 3'(i), 4'(i), 16'h0300 + 16'(i), 16'h3000 + 16'(i),
                       16'h0B00 + 16'(i), 1'b0, 5'b00010), 1'b0, 1'b1, "pushpop old");
      recv_frame(mk(1'b1, 3'd4, 4'd5, 16'h0400, 16'h4000, 16'hCAFE, 1'b0, 5'b00100),
                 1'b0, 1'b1, "pushpop new");
   endtask

   task automatic test_no_wr();
      do_reset();
      retire(16'h1234, 16'h5678, 1'b0, 4'd7, 16'hBEEF, 5'b10110);
      recv_frame(72'hA5_07_12_34_56_78_00_00_16, 1'b0, 1'b1, "no_wr");
   endtask

   task automatic test_drop_saturate();
      do_reset();
      tx_ready = 1'b0;
      for (int i = 0; i < 264; i++)
         retire(16'(i), 16'h0000, 1'b1, 4'd0, 16'h0000, 5'b00000);
      check_val("saturate drop_cnt", drop_cnt, 8'hFF);
      check_val("saturate level", {5'b0, fifo_level}, 8'h04);
      tx_ready = 1'b1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         retire(16'h0500 + 16'(i), 16'h7700 + 16'(i), 1'b1, 4'd2, 16'h0001, 5'b00001);
      tx_ready = 1'b1;
      repeat (4) step();
      check_val("midreset at b4", tx_data, 8'h77);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_val("midreset tx_valid", {7'b0, tx_valid}, 8'h00);
      check_val("midreset level", {5'b0, fifo_level}, 8'h00);
      check_val("midreset drop_cnt", drop_cnt, 8'h00);
      retire(16'h0600, 16'h8800, 1'b1, 4'd4, 16'h4321, 5'b00011);
      recv_frame(mk(1'b1, 3'd0, 4'd4, 16'h0600, 16'h8800, 16'h4321, 1'b0, 5'b00011),
                 1'b0, 1'b1, "midreset next");
   endtask

   initial begin
      rst = 1'b1;
      trace_en = 1'b1;
      retire_valid = 1'b0;
      retire_pc = '0;
      retire_instr = '0;
      retire_wr_en = 1'b0;
      retire_wr_reg = '0;
      retire_wr_data = '0;
      retire_flags = '0;
      tx_ready = 1'b1;
      test_reset();
      test_trace_en();
      test_single();
      test_backpressure();
      test_overflow();
      test_full_push_on_pop();
      test_no_wr();
      test_drop_saturate();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
